e_mdu_ctrl: RTL and testbench
=============================

E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, meaning busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYC, default 10, meaning busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; 0 at a rising edge resets all state.
REQ-005 SHALL have port start  input  1  md-class instruction (mult/multu/div/divu) valid in E stage this cycle.
REQ-006 SHALL have port md_op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 SHALL have port mt  input  1  mthi/mtlo valid in E stage.
REQ-008 SHALL have port mt_hi  input  1  1 = mthi, 0 = mtlo.
REQ-009 SHALL have port mf_hi  input  1  mf_data source select: 1 = HI, 0 = LO.
REQ-010 SHALL have port A  input  32  rs operand (dividend/multiplicand; mt data).
REQ-011 SHALL have port B  input  32  rt operand (divisor/multiplier).
REQ-012 SHALL have port d_md  input  1  D-stage instruction is md, mt or mf class.
REQ-013 SHALL have port busy  output  1  operation in progress.
REQ-014 SHALL have port stall  output  1  hold D stage and freeze F/D registers.
REQ-015 SHALL have port done  output  1  one-cycle pulse: new HI/LO visible.
REQ-016 SHALL have port HI  output  32  HI register.
REQ-017 SHALL have port LO  output  32  LO register.
REQ-018 SHALL have port mf_data  output  32  combinational mf_hi ? HI : LO.

Function
REQ-019 SHALL implement states IDLE and RUN with a down-counter cnt, wide enough for max(MULT_CYC, DIV_CYC).
REQ-020 SHALL, in IDLE with start=1 at edge T, latch A, B and md_op, load cnt with MULT_CYC or DIV_CYC, and enter RUN.
REQ-021 SHALL drive busy = (state==RUN) as a registered signal: 1 in cycles T+1..T+N, where N is the loaded count.
REQ-022 SHALL decrement cnt at each RUN edge; at the edge where cnt goes 1->0, write HI/LO and return to IDLE.
REQ-023 SHALL pulse done=1 in cycle T+N+1 only.
REQ-024 SHALL, for mult, write the signed 64-bit product A*B as {HI,LO}; for multu, the unsigned product.
REQ-025 SHALL, for div, write LO = quotient truncated toward zero and HI = remainder with sign of dividend; 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-026 SHALL, for divu, write LO = unsigned quotient and HI = unsigned remainder.
REQ-027 SHALL, when divisor is 0, still run DIV_CYC cycles and pulse done, but leave HI/LO unchanged.
REQ-028 SHALL compute results only from latched operands; A/B changes during RUN have no effect.
REQ-029 SHALL, with mt=1 in IDLE and start=0, write A to HI (mt_hi=1) or LO (mt_hi=0) at that edge; done stays 0.
REQ-030 SHALL ignore start and mt while in RUN.
REQ-031 SHALL give start priority when start and mt are both 1 in IDLE; the mt write is dropped.
REQ-032 SHALL drive stall = d_md & (start | busy), combinationally.
REQ-033 SHALL drive mf_data combinationally, so an mf in E reads HI/LO in the same cycle.

Reset
REQ-034 SHALL, on reset=0 at an edge, set state=IDLE, cnt=0, HI=0, LO=0, busy=0, done=0 and discard latched operands.
REQ-035 SHALL let reset mid-RUN cancel the operation, with no HI/LO write and no done pulse.
REQ-036 SHALL give reset priority over start and mt in the same cycle.

Verification
REQ-037 SHALL check mult: A=0xFFFFFFFF, B=2, start at T -> busy in T+1..T+5, done in T+6, HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu gives HI=1, LO=0xFFFFFFFE.
REQ-038 SHALL check div: A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> done pulses, HI/LO unchanged.
REQ-039 SHALL check stall: d_md=1 held from T -> stall=1 in T..T+10 for div, stall=0 in T+11; with d_md=0, stall=0 throughout.
REQ-040 SHALL check mt: mthi A=0x12345678 in IDLE -> HI=0x12345678 next cycle; mtlo during RUN -> LO unchanged; start+mt together -> only md executes.
REQ-041 SHALL check reset mid-RUN: reset=0 at cycle T+3 of mult -> busy=0, HI=LO=0, no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/e_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu_ctrl
// Brief    : Multi-cycle multiply/divide unit controller for the E stage.
//            Holds HI/LO, sequences mult/multu/div/divu over a fixed number
//            of busy cycles, services mthi/mtlo and drives the D-stage stall.
// Revision : 1.0 - initial release
// ============================================================================
module e_mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        mt,
  input  logic        mt_hi,
  input  logic        mf_hi,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        d_md,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mf_data
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept;     // start taken this cycle
  logic             finish;     // last RUN edge: results become visible
  logic             mt_wr;      // mthi/mtlo write this cycle

  // Operands captured at start; results use only these.
  logic [31:0]      op_a, op_b;
  logic [1:0]       op;

  logic             is_signed;
  logic             neg_a, neg_b;
  logic [63:0]      ext_a, ext_b, prod;
  logic [31:0]      mag_a, mag_b, q_mag, r_mag, quot, rem;
  logic [63:0]      result;
  logic             write_ok;

  // Next-state and control decode; start outranks mt, RUN ignores both.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    finish    = 1'b0;
    mt_wr     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = md_op[1] ? DIV_LOAD : MULT_LOAD;
          accept    = 1'b1;
        end else if (mt) begin
          mt_wr = 1'b1;
        end
      end
      RUN: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and down-counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Operand latch; cleared on reset so no stale operation survives it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_a <= '0;
      op_b <= '0;
      op   <= '0;
    end else if (accept) begin
      op_a <= A;
      op_b <= B;
      op   <= md_op;
    end
  end

  // Arithmetic on the latched operands: one 64-bit multiplier for both
  // signednesses (sign/zero extension), one unsigned divider on magnitudes.
  always_comb begin
    is_signed = ~op[0];
    neg_a     = is_signed & op_a[31];
    neg_b     = is_signed & op_b[31];
    ext_a     = {{32{neg_a}}, op_a};
    ext_b     = {{32{neg_b}}, op_b};
    prod      = ext_a * ext_b;
    mag_a     = neg_a ? (32'd0 - op_a) : op_a;
    mag_b     = neg_b ? (32'd0 - op_b) : op_b;
    q_mag     = (mag_b == 32'd0) ? 32'd0 : (mag_a / mag_b);
    r_mag     = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
    // Quotient truncates toward zero; remainder follows the dividend.
    // 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
    quot      = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem       = neg_a ? (32'd0 - r_mag) : r_mag;
    result    = op[1] ? {rem, quot} : prod;
    // Division by zero completes its cycles but leaves HI/LO untouched.
    write_ok  = ~(op[1] & (op_b == 32'd0));
  end

  // HI/LO update and done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      HI   <= '0;
      LO   <= '0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (finish && write_ok) begin
        HI <= result[63:32];
        LO <= result[31:0];
      end else if (mt_wr) begin
        if (mt_hi) HI <= A;
        else       LO <= A;
      end
    end
  end

  assign busy    = (state == RUN);
  assign stall   = d_md & (start | busy);
  assign mf_data = mf_hi ? HI : LO;

endmodule
`default_nettype wire

// File: tb/tb_e_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_mdu_ctrl
// Brief    : Self-checking bench for e_mdu_ctrl: directed cases with literal
//            expectations plus randomized traffic against a timestamp/64-bit
//            arithmetic reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, start, mt, mt_hi, mf_hi, d_md;
  logic [1:0]  md_op;
  logic [31:0] A, B;
  logic        busy, stall, done;
  logic [31:0] HI, LO, mf_data;

  int checks   = 0;
  int failures = 0;

  e_mdu_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .mt(mt),
    .mt_hi(mt_hi), .mf_hi(mf_hi), .A(A), .B(B), .d_md(d_md),
    .busy(busy), .stall(stall), .done(done), .HI(HI), .LO(LO),
    .mf_data(mf_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // An operation started at edge e completes at edge e+N; results are
  // computed up front with 64-bit integer arithmetic.
  int          ecnt = 0;
  int          m_end = 0;
  bit          m_valid = 1'b0;
  bit          m_run = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  bit          p_wr;
  logic [31:0] p_hi, p_lo;

  task automatic model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint x, y, r, q;
    p_wr = 1'b1;
    case (op)
      2'b00: begin
        x = longint'($signed(a)); y = longint'($signed(b)); r = x * y;
        p_hi = r[63:32]; p_lo = r[31:0];
      end
      2'b01: begin
        x = longint'({32'd0, a}); y = longint'({32'd0, b}); r = x * y;
        p_hi = r[63:32]; p_lo = r[31:0];
      end
      2'b10: begin
        if (b == 32'd0) p_wr = 1'b0;
        else begin
          x = longint'($signed(a)); y = longint'($signed(b));
          q = x / y; r = x % y;
          p_hi = r[31:0]; p_lo = q[31:0];
        end
      end
      default: begin
        if (b == 32'd0) p_wr = 1'b0;
        else begin
          x = longint'({32'd0, a}); y = longint'({32'd0, b});
          q = x / y; r = x % y;
          p_hi = r[31:0]; p_lo = q[31:0];
        end
      end
    endcase
  endtask

  // Model advances on every rising edge from the inputs seen at that edge.
  always @(posedge clk) begin
    ecnt++;
    if (!reset) begin
      m_valid = 1'b1;
      m_run   = 1'b0;
      m_done  = 1'b0;
      m_hi    = '0;
      m_lo    = '0;
    end else begin
      m_done = 1'b0;
      if (m_run) begin
        if (ecnt == m_end) begin
          m_run  = 1'b0;
          m_done = 1'b1;
          if (p_wr) begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
        end
      end else if (start) begin
        model_result(md_op, A, B);
        m_run = 1'b1;
        m_end = ecnt + (md_op[1] ? DIV_N : MULT_N);
      end else if (mt) begin
        if (mt_hi) m_hi = A;
        else       m_lo = A;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_busy", busy, m_run);
      chk("cmp_done", done, m_done);
      chk("cmp_hi", HI, m_hi);
      chk("cmp_lo", LO, m_lo);
      chk("cmp_mf", mf_data, mf_hi ? m_hi : m_lo);
      chk("cmp_stall", stall, d_md & (start | m_run));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_md(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int n,
                       input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input logic with_mt);
    start = 1'b1; md_op = op; A = a; B = b; mt = with_mt; mt_hi = 1'b1;
    #1;
    chk({nm, "_stall_T"}, stall, d_md);
    step();
    start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      A = $urandom; B = $urandom; mt_hi = k[0];
      #1;
      chk({nm, "_busy"}, busy, 1'b1);
      chk({nm, "_nodone"}, done, 1'b0);
      chk({nm, "_stall_run"}, stall, d_md);
      chk({nm, "_hi_hold"}, HI, pre_hi);
      chk({nm, "_lo_hold"}, LO, pre_lo);
      step();
    end
    mt = 1'b0;
    #1;
    chk({nm, "_busy_end"}, busy, 1'b0);
    chk({nm, "_done"}, done, 1'b1);
    chk({nm, "_stall_end"}, stall, 1'b0);
    chk({nm, "_hi"}, HI, exp_hi);
    chk({nm, "_lo"}, LO, exp_lo);
    step();
    chk({nm, "_done_pulse"}, done, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return 32'd0 - 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed scenarios then randomized traffic.
  initial begin
    reset = 1'b0; start = 1'b0; md_op = 2'b00; mt = 1'b0; mt_hi = 1'b0;
    mf_hi = 1'b0; A = '0; B = '0; d_md = 1'b0;
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    reset = 1'b1;

    do_md("mult",  2'b00, 32'hFFFF_FFFF, 32'd2, MULT_N, 32'h0, 32'h0,
          32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_md("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
          32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    d_md = 1'b1;
    do_md("div",   2'b10, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'h0000_0001, 32'hFFFF_FFFE,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    d_md = 1'b0;
    do_md("divu0", 2'b11, 32'd7, 32'd0, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_md("divovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
          32'h0000_0000, 32'h8000_0000, 1'b0);

    mt = 1'b1; mt_hi = 1'b1; A = 32'h1234_5678;
    step();
    mt = 1'b0;
    #1;
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_lo", LO, 32'h8000_0000);
    chk("mthi_done", done, 1'b0);
    mf_hi = 1'b1; #1;
    chk("mf_hi_sel", mf_data, 32'h1234_5678);
    mf_hi = 1'b0; #1;
    chk("mf_lo_sel", mf_data, 32'h8000_0000);

    // mt asserted with start and throughout RUN: only the multiply lands.
    do_md("mult_mt", 2'b00, 32'd3, 32'd4, MULT_N, 32'h1234_5678, 32'h8000_0000,
          32'h0, 32'd12, 1'b1);

    // Reset asserted in cycle T+3 of a multiply.
    start = 1'b1; md_op = 2'b00; A = 32'hFFFF_FFFF; B = 32'd2;
    step();
    start = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("rst_run_busy", busy, 1'b0);
    chk("rst_run_hi", HI, 32'h0);
    chk("rst_run_lo", LO, 32'h0);
    for (int k = 0; k < 8; k++) begin
      chk("rst_run_nodone", done, 1'b0);
      step();
    end
    do_md("after_rst", 2'b01, 32'hFFFF_FFFF, 32'd2, MULT_N, 32'h0, 32'h0,
          32'h0000_0001, 32'hFFFF_FFFE, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 5) == 0);
      md_op = 2'($urandom);
      mt    = ($urandom_range(0, 3) == 0);
      mt_hi = 1'($urandom);
      mf_hi = 1'($urandom);
      d_md  = 1'($urandom);
      A     = pick();
      B     = pick();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
